input_mem: RTL

//  Input-side pixel buffer of the rotate engine; mirror of the output packer.

---
 rtl/rotate_pkg.sv | 13 +
 rtl/imem_ram.sv | 45 ++++
 rtl/input_mem.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// Shared encodings and byte-geometry constants for the rotate engine buffers.
package rotate_pkg;

  typedef enum logic [1:0] {
    IMEM_ST_IDLE  = 2'd0,
    IMEM_ST_FILL  = 2'd1,
    IMEM_ST_READY = 2'd2
  } imem_state_e;

  localparam int PIX_BYTES  = 3;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_ram.sv
// Tile storage for input_mem: four byte lanes written one aligned 32-bit word at a time,
// with PIX_BYTES registered byte read ports that can be loaded together or cleared together.
module imem_ram
  import rotate_pkg::*;
#(
  parameter int WORDS  = 48,
  parameter int ADDR_W = 8
) (
  input  logic                               I_IMEM_HCLK,
  input  logic                               I_IMEM_HRESET,
  input  logic                               wr_en,
  input  logic [ADDR_W-3:0]                  wr_row,
  input  logic [31:0]                        wr_data,
  input  logic                               rd_en,
  input  logic                               rd_clr,
  input  logic [PIX_BYTES-1:0][ADDR_W-1:0]   rd_addr,
  output logic [PIX_BYTES-1:0][7:0]          rd_data
);

  // Byte address = {row, lane}; lane selects which byte of the stored word.
  logic [7:0] mem [WORD_BYTES][WORDS];

  always_ff @(posedge I_IMEM_HCLK) begin
    if (wr_en) begin
      for (int l = 0; l < WORD_BYTES; l++) begin
        mem[l][wr_row] <= wr_data[8*l +: 8];
      end
    end
  end

  // Read registers are the pixel outputs: they hold between requests and are
  // zeroed on reset or on a rejected request.
  always_ff @(posedge I_IMEM_HCLK or posedge I_IMEM_HRESET) begin
    if (I_IMEM_HRESET) begin
      rd_data <= '0;
    end else if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int k = 0; k < PIX_BYTES; k++) begin
        rd_data[k] <= mem[rd_addr[k][1:0]][rd_addr[k][ADDR_W-1:2]];
      end
    end
  end

endmodule

// File: rtl/input_mem.sv
// Input-side tile buffer of the rotate engine: fills from AHB read words, then
// serves B/G/R byte triples by byte address with a one-cycle latency.
module input_mem
  import rotate_pkg::*;
#(
  parameter int DEPTH_BYTES = 192,
  parameter int ADDR_W      = 8
) (
  input  logic              I_IMEM_HCLK,
  input  logic              I_IMEM_HRESET,
  input  logic              I_IMEM_START,
  input  logic [31:0]       I_IMEM_RDATA,
  input  logic              I_IMEM_RVALID,
  output logic              O_IMEM_RREADY,
  output logic              O_IMEM_FULL,
  input  logic              I_IMEM_RELEASE,
  input  logic              I_IMEM_PIXEL_REQ,
  input  logic [ADDR_W-1:0] I_IMEM_PIXEL_ADDR,
  output logic [7:0]        O_IMEM_PIXEL_B,
  output logic [7:0]        O_IMEM_PIXEL_G,
  output logic [7:0]        O_IMEM_PIXEL_R,
  output logic              O_IMEM_PIXEL_VALID,
  output logic              O_IMEM_PIXEL_ERR
);

  localparam int WORDS = DEPTH_BYTES / WORD_BYTES;
  localparam int ROW_W = ADDR_W - 2;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(WORDS - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH_BYTES);

  imem_state_e                      state;
  logic [ROW_W-1:0]                 word_cnt;
  logic                             accept;
  logic [ADDR_W:0]                  last_addr;
  logic                             pix_ok;
  logic                             pix_bad;
  logic [PIX_BYTES-1:0][ADDR_W-1:0] rd_addr;
  logic [PIX_BYTES-1:0][7:0]        rd_data;

  assign O_IMEM_RREADY = (state == IMEM_ST_FILL);
  assign accept        = I_IMEM_RVALID & O_IMEM_RREADY;

  // Widened by one bit so a request near the top of the address space cannot
  // wrap back into the tile and pass the range check.
  assign last_addr = {1'b0, I_IMEM_PIXEL_ADDR} + (ADDR_W+1)'(PIX_BYTES - 1);
  assign pix_ok    = I_IMEM_PIXEL_REQ && (state == IMEM_ST_READY) && (last_addr < DEPTH_LIM);
  assign pix_bad   = I_IMEM_PIXEL_REQ && !pix_ok;

  always_comb begin
    rd_addr = '0;
    for (int k = 0; k < PIX_BYTES; k++) begin
      rd_addr[k] = I_IMEM_PIXEL_ADDR + ADDR_W'(k);
    end
  end

  always_ff @(posedge I_IMEM_HCLK or posedge I_IMEM_HRESET) begin
    if (I_IMEM_HRESET) begin
      state              <= IMEM_ST_IDLE;
      word_cnt           <= '0;
      O_IMEM_FULL        <= 1'b0;
      O_IMEM_PIXEL_VALID <= 1'b0;
      O_IMEM_PIXEL_ERR   <= 1'b0;
    end else begin
      O_IMEM_PIXEL_VALID <= pix_ok;
      O_IMEM_PIXEL_ERR   <= pix_bad;
      // START overrides everything, including RELEASE and a final accept.
      if (I_IMEM_START) begin
        state       <= IMEM_ST_FILL;
        word_cnt    <= '0;
        O_IMEM_FULL <= 1'b0;
      end else begin
        case (state)
          IMEM_ST_IDLE: begin
            O_IMEM_FULL <= 1'b0;
          end
          IMEM_ST_FILL: begin
            if (accept) begin
              if (word_cnt == LAST_ROW) begin
                state       <= IMEM_ST_READY;
                word_cnt    <= '0;
                O_IMEM_FULL <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
          IMEM_ST_READY: begin
            if (I_IMEM_RELEASE) begin
              state       <= IMEM_ST_IDLE;
              O_IMEM_FULL <= 1'b0;
            end
          end
          default: begin
            state       <= IMEM_ST_IDLE;
            word_cnt    <= '0;
            O_IMEM_FULL <= 1'b0;
          end
        endcase
      end
    end
  end

  imem_ram #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .I_IMEM_HCLK   (I_IMEM_HCLK),
    .I_IMEM_HRESET (I_IMEM_HRESET),
    .wr_en         (accept),
    .wr_row        (word_cnt),
    .wr_data       (I_IMEM_RDATA),
    .rd_en         (pix_ok),
    .rd_clr        (pix_bad),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  assign O_IMEM_PIXEL_B = rd_data[0];
  assign O_IMEM_PIXEL_G = rd_data[1];
  assign O_IMEM_PIXEL_R = rd_data[2];

endmodule
